// File: rtl/load_store_unit.sv
// Load/store unit: RV32I B/H/W/BU/HU loads with extension; sub-word stores via read-modify-write.
// Latency accept->response: load 2, SW 2, SB/SH 3, misaligned trap 1 (only with LSU_MISALIGN_TRAP_EN).
// Backpressure: oReady only in IDLE; the response is held stable until iRspReady is sampled high.
module load_store_unit (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iValid,
    output logic        oReady,
    input  logic        iStore,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oValid,
    input  logic        iRspReady,
    output logic [31:0] oRData,
    output logic        oFault,
    output logic        oMemEn,
    output logic        oMemReadnWrite,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    input  logic [31:0] iMemData
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [15:0] wdata_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic        mem_en_q;
    logic        mem_rnw_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;

    logic [2:0]  f3_n;
    logic        misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    // Ready is combinational on state so it is low throughout reset.
    assign oReady         = (state == IDLE) && nRst;
    assign oValid         = valid_q;
    assign oRData         = rdata_q;
    assign oFault         = fault_q;
    assign oMemEn         = mem_en_q;
    assign oMemReadnWrite = mem_rnw_q;
    assign oMemAddr       = mem_addr_q;
    assign oMemData       = mem_data_q;

    // Normalise funct3: reserved codes and unsigned stores collapse to a word access.
    always_comb begin
        f3_n = 3'b010;
        case (iFunct3)
            3'b000, 3'b001, 3'b010: f3_n = iFunct3;
            3'b100, 3'b101:         f3_n = iStore ? 3'b010 : iFunct3;
            default:                f3_n = 3'b010;
        endcase
    end

    // Misalignment detection; without the trap the low address bits are simply ignored.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (((f3_n == 3'b001) || (f3_n == 3'b101)) && iAddr[0]) ||
                   ((f3_n == 3'b010) && (iAddr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Load lane selection (little-endian) and sign/zero extension of the read word.
    always_comb begin
        ld_byte = 8'(iMemData >> {lo_q, 3'b000});
        ld_half = lo_q[1] ? iMemData[31:16] : iMemData[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = iMemData;
        endcase
    end

    // Sub-word store merge: replace the addressed byte/halfword of the read word.
    always_comb begin
        if (f3_q == 3'b000) begin
            st_merge = (iMemData & ~(32'h0000_00ff << {lo_q, 3'b000})) |
                       ({24'h0, wdata_q[7:0]} << {lo_q, 3'b000});
        end else begin
            st_merge = (iMemData & ~(32'h0000_ffff << {lo_q[1], 4'b0000})) |
                       ({16'h0, wdata_q} << {lo_q[1], 4'b0000});
        end
    end

    // Control FSM; all memory and response outputs are registered here.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            f3_q       <= 3'b000;
            lo_q       <= 2'b00;
            wdata_q    <= 16'h0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= 32'h0;
            mem_en_q   <= 1'b0;
            mem_rnw_q  <= 1'b1;
            mem_addr_q <= 32'h0;
            mem_data_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        f3_q    <= f3_n;
                        lo_q    <= iAddr[1:0];
                        wdata_q <= iWData[15:0];
                        if (misalign) begin
                            valid_q <= 1'b1;
                            fault_q <= 1'b1;
                            rdata_q <= 32'h0;
                            state   <= RESP;
                        end else begin
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= {2'b00, iAddr[31:2]};
                            if (!iStore) begin
                                mem_rnw_q <= 1'b1;
                                state     <= LOAD;
                            end else if (f3_n == 3'b010) begin
                                mem_rnw_q  <= 1'b0;
                                mem_data_q <= iWData;
                                state      <= WRITE;
                            end else begin
                                mem_rnw_q <= 1'b1;
                                state     <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    rdata_q    <= ld_ext;
                    valid_q    <= 1'b1;
                    fault_q    <= 1'b0;
                    mem_en_q   <= 1'b0;
                    mem_rnw_q  <= 1'b1;
                    mem_addr_q <= 32'h0;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_data_q <= st_merge;
                    mem_rnw_q  <= 1'b0;
                    state      <= WRITE;
                end
                WRITE: begin
                    mem_en_q   <= 1'b0;
                    mem_rnw_q  <= 1'b1;
                    mem_addr_q <= 32'h0;
                    mem_data_q <= 32'h0;
                    valid_q    <= 1'b1;
                    fault_q    <= 1'b0;
                    rdata_q    <= 32'h0;
                    state      <= RESP;
                end
                RESP: begin
                    if (iRspReady) begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                        rdata_q <= 32'h0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word combinational-read memory.
// Latency is counted in rising edges from the accepting edge to the first oValid cycle.
// Expected values are hand-computed constants.
module tb_load_store_unit;

    logic        iClk = 1'b0;
    logic        nRst;
    logic        iValid;
    logic        oReady;
    logic        iStore;
    logic [2:0]  iFunct3;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic        oValid;
    logic        iRspReady;
    logic [31:0] oRData;
    logic        oFault;
    logic        oMemEn;
    logic        oMemReadnWrite;
    logic [31:0] oMemAddr;
    logic [31:0] oMemData;
    logic [31:0] iMemData;

    logic [31:0] mem [64];
    logic        bk_we;
    logic [5:0]  bk_addr;
    logic [31:0] bk_data;
    int          wr_cnt = 0;
    int          en_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    int total = 0;
    int bad   = 0;
    int lat;
    int wr0;
    int en0;
    logic [31:0] held;

    load_store_unit dut (
        .iClk(iClk), .nRst(nRst), .iValid(iValid), .oReady(oReady),
        .iStore(iStore), .iFunct3(iFunct3), .iAddr(iAddr), .iWData(iWData),
        .oValid(oValid), .iRspReady(iRspReady), .oRData(oRData), .oFault(oFault),
        .oMemEn(oMemEn), .oMemReadnWrite(oMemReadnWrite), .oMemAddr(oMemAddr),
        .oMemData(oMemData), .iMemData(iMemData)
    );

    always #5 iClk = ~iClk;

    assign iMemData = (oMemEn && oMemReadnWrite && (oMemAddr < 32'd64)) ? mem[oMemAddr[5:0]] : 32'h0;

    // Memory write port plus activity counters.
    always @(posedge iClk) begin
        if (bk_we) begin
            mem[bk_addr] <= bk_data;
        end else if (oMemEn && !oMemReadnWrite) begin
            if (oMemAddr < 32'd64) mem[oMemAddr[5:0]] <= oMemData;
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = oMemAddr;
            last_wr_data = oMemData;
        end
        if (oMemEn) en_cnt = en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and count edges until oValid (bounded).
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int l);
        int n = 0;
        @(negedge iClk);
        while (!oReady && n < 20) begin
            @(negedge iClk);
            n++;
        end
        iValid = 1'b1; iStore = st; iFunct3 = f3; iAddr = a; iWData = wd;
        @(negedge iClk);
        iValid = 1'b0;
        l = 1;
        while (!oValid && l < 20) begin
            @(negedge iClk);
            l++;
        end
    endtask

    task automatic rsp();
        iRspReady = 1'b1;
        @(negedge iClk);
        iRspReady = 1'b0;
    endtask

    initial begin
        nRst = 1'b0; iValid = 1'b0; iStore = 1'b0; iFunct3 = 3'b000;
        iAddr = 32'h0; iWData = 32'h0; iRspReady = 1'b0;
        bk_we = 1'b1; bk_addr = 6'd0; bk_data = 32'h0000_0037;
        @(posedge iClk); #1;
        bk_addr = 6'd8; bk_data = 32'h1111_2222;
        @(posedge iClk); #1;
        bk_we = 1'b0;
        @(negedge iClk);
        chk("rst_ready", {31'h0, oReady}, 32'h0);
        chk("rst_valid", {31'h0, oValid}, 32'h0);
        chk("rst_fault", {31'h0, oFault}, 32'h0);
        chk("rst_rdata", oRData, 32'h0);
        chk("rst_memen", {31'h0, oMemEn}, 32'h0);
        chk("rst_rnw", {31'h0, oMemReadnWrite}, 32'h1);
        chk("rst_maddr", oMemAddr, 32'h0);
        chk("rst_mdata", oMemData, 32'h0);
        nRst = 1'b1;
        #1;
        chk("ready_after_rst", {31'h0, oReady}, 32'h1);

        // LB from word 0
        send(1'b0, 3'b000, 32'h0, 32'h0, lat);
        chk("lb0_lat", lat, 2);
        chk("lb0_data", oRData, 32'h0000_0037);
        chk("lb0_fault", {31'h0, oFault}, 32'h0);
        rsp();

        // SW then sub-word loads
        wr0 = wr_cnt;
        send(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat);
        chk("sw_lat", lat, 2);
        chk("sw_rdata", oRData, 32'h0);
        chk("sw_wr_cnt", wr_cnt - wr0, 1);
        chk("sw_wr_addr", last_wr_addr, 32'h4);
        chk("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
        rsp();
        send(1'b0, 3'b000, 32'h13, 32'h0, lat);
        chk("lb13", oRData, 32'hFFFF_FFDE);
        rsp();
        send(1'b0, 3'b100, 32'h13, 32'h0, lat);
        chk("lbu13", oRData, 32'h0000_00DE);
        rsp();
        send(1'b0, 3'b001, 32'h12, 32'h0, lat);
        chk("lh12", oRData, 32'hFFFF_DEAD);
        rsp();
        send(1'b0, 3'b101, 32'h10, 32'h0, lat);
        chk("lhu10", oRData, 32'h0000_BEEF);
        rsp();

        // SH read-modify-write
        wr0 = wr_cnt;
        send(1'b1, 3'b001, 32'h12, 32'h0000_1234, lat);
        chk("sh_lat", lat, 3);
        chk("sh_wr_cnt", wr_cnt - wr0, 1);
        chk("sh_wr_addr", last_wr_addr, 32'h4);
        chk("sh_wr_data", last_wr_data, 32'h1234_BEEF);
        rsp();

        // Held response under backpressure
        send(1'b0, 3'b101, 32'h12, 32'h0, lat);
        held = oRData;
        chk("hold_first", held, 32'h0000_1234);
        en0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            chk("hold_valid", {31'h0, oValid}, 32'h1);
            chk("hold_rdata", oRData, 32'h0000_1234);
            chk("hold_ready", {31'h0, oReady}, 32'h0);
        end
        chk("hold_no_mem", en_cnt - en0, 0);
        rsp();
        chk("release_ready", {31'h0, oReady}, 32'h1);
        chk("release_valid", {31'h0, oValid}, 32'h0);

        // Misaligned LW
        en0 = en_cnt;
        send(1'b0, 3'b010, 32'h11, 32'h0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw11_lat", lat, 1);
        chk("lw11_fault", {31'h0, oFault}, 32'h1);
        chk("lw11_rdata", oRData, 32'h0);
        chk("lw11_no_mem", en_cnt - en0, 0);
`else
        chk("lw11_lat", lat, 2);
        chk("lw11_fault", {31'h0, oFault}, 32'h0);
        chk("lw11_rdata", oRData, 32'h1234_BEEF);
`endif
        rsp();

        // SB into byte lane 1, then an illegal funct3 load behaving as LW
        wr0 = wr_cnt;
        send(1'b1, 3'b000, 32'h11, 32'h0000_00AB, lat);
        chk("sb_lat", lat, 3);
        chk("sb_wr_cnt", wr_cnt - wr0, 1);
        chk("sb_wr_data", last_wr_data, 32'h1234_ABEF);
        rsp();
        send(1'b0, 3'b011, 32'h10, 32'h0, lat);
        chk("ill_f3_lat", lat, 2);
        chk("ill_f3_data", oRData, 32'h1234_ABEF);
        rsp();

        // Reset in the middle of a SW's WRITE cycle
        wr0 = wr_cnt;
        iValid = 1'b1; iStore = 1'b1; iFunct3 = 3'b010; iAddr = 32'h20; iWData = 32'hCAFE_F00D;
        @(negedge iClk);
        iValid = 1'b0;
        chk("rstw_in_write", {31'h0, oMemEn & ~oMemReadnWrite}, 32'h1);
        #1 nRst = 1'b0;
        #1;
        chk("rstw_memen", {31'h0, oMemEn}, 32'h0);
        chk("rstw_ready", {31'h0, oReady}, 32'h0);
        @(negedge iClk);
        @(negedge iClk);
        nRst = 1'b1;
        chk("rstw_no_write", wr_cnt - wr0, 0);
        chk("rstw_valid", {31'h0, oValid}, 32'h0);
        send(1'b0, 3'b010, 32'h20, 32'h0, lat);
        chk("rstw_lw_lat", lat, 2);
        chk("rstw_lw_data", oRData, 32'h1111_2222);
        rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
